// File: rtl/immediate_encoder_if.sv
// Handshake bundle for immediate_encoder.
//  master : producer/consumer side (drives value_in/min_op_in/in_valid and out_ready)
//  slave  : encoder side (drives in_ready and the result fields)
//  in_valid/in_ready   : request handshake carrying value_in (32b) and min_op_in (2b)
//  out_valid/out_ready : result handshake carrying imm_out (24b), op_out (2b), err_out
interface immediate_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value_in;
  logic [1:0]  min_op_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] imm_out;
  logic [1:0]  op_out;
  logic        err_out;

  modport master (
    output in_valid, value_in, min_op_in, out_ready,
    input  in_ready, out_valid, imm_out, op_out, err_out
  );

  modport slave (
    input  in_valid, value_in, min_op_in, out_ready,
    output in_ready, out_valid, imm_out, op_out, err_out
  );
endinterface

// File: rtl/immediate_encoder.sv
// immediate_encoder: packs a 32-bit signed constant into the shortest immediate
// format the decode path can sign-extend back (op 00 = 8b, 01 = 12b, 10 = 24b,
// 11 = not encodable). One candidate format is tested per cycle.
//  clk  : rising-edge clock
//  rst  : synchronous active-high reset
//  bus  : immediate_encoder_if.slave (request in, result out)
// Parameters:
//  SKIP_8    : 1 = never emit op 00; a floor of 00 starts at the 12-bit check
//  DONE_HOLD : 1 = hold the result until out_ready; 0 = single-cycle out_valid
module immediate_encoder #(
  parameter bit SKIP_8    = 1'b0,
  parameter bit DONE_HOLD = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  immediate_encoder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CHK8, CHK12, CHK24, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] val_q, val_d;
  logic [23:0] imm_q, imm_d;
  logic [1:0]  op_q, op_d;
  logic        err_q, err_d;

  // fits[g]: value is representable in the g-th format width. The format floor
  // is carried by the entry state chosen at accept time, so no separate copy of
  // min_op is kept past IDLE.
  logic [2:0] fits;
  for (genvar g = 0; g < 3; g++) begin : g_fit
    localparam int N = (g == 0) ? 8 : (g == 1) ? 12 : 24;
    assign fits[g] = (&val_q[31:N-1]) | ~(|val_q[31:N-1]);
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    imm_d   = imm_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          val_d = bus.value_in;
          case (bus.min_op_in)
            2'b00:   state_d = SKIP_8 ? CHK12 : CHK8;
            2'b01:   state_d = CHK12;
            2'b10:   state_d = CHK24;
            default: begin
              state_d = DONE;
              imm_d   = '0;
              op_d    = 2'b11;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      CHK8: begin
        if (fits[0]) begin
          state_d = DONE;
          imm_d   = {16'd0, val_q[7:0]};
          op_d    = 2'b00;
          err_d   = 1'b0;
        end else begin
          state_d = CHK12;
        end
      end
      CHK12: begin
        if (fits[1]) begin
          state_d = DONE;
          imm_d   = {12'd0, val_q[11:0]};
          op_d    = 2'b01;
          err_d   = 1'b0;
        end else begin
          state_d = CHK24;
        end
      end
      CHK24: begin
        state_d = DONE;
        if (fits[2]) begin
          imm_d = val_q[23:0];
          op_d  = 2'b10;
          err_d = 1'b0;
        end else begin
          imm_d = '0;
          op_d  = 2'b11;
          err_d = 1'b1;
        end
      end
      DONE: begin
        if (!DONE_HOLD || bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers only change on entry to DONE, so they stay stable while
  // out_valid waits on out_ready and keep their value after leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      val_q   <= '0;
      imm_q   <= '0;
      op_q    <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      imm_q   <= imm_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.imm_out   = imm_q;
  assign bus.op_out    = op_q;
  assign bus.err_out   = err_q;

endmodule

// File: tb/tb_immediate_encoder.sv
module tb_immediate_encoder;
  localparam bit SKIP8 = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  immediate_encoder_if bus();

  immediate_encoder #(.SKIP_8(SKIP8), .DONE_HOLD(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: pick the first format, starting at the floor, whose signed range
  // [-2^(w-1), 2^(w-1)-1] contains the value. Latency = formats tried + 1.
  function automatic void ref_model(input logic [31:0] v, input logic [1:0] mn,
                                    output logic [1:0] op, output logic [23:0] imm,
                                    output logic err, output int lat);
    longint sv;
    int     w;
    int     start;
    bit     found;
    sv    = longint'($signed(v));
    op    = 2'b11;
    imm   = '0;
    err   = 1'b1;
    lat   = 1;
    found = 1'b0;
    if (mn == 2'b11) return;
    start = int'(mn);
    if (start == 0 && SKIP8) start = 1;
    for (int k = start; k < 3; k++) begin
      if (!found) begin
        w = (k == 0) ? 8 : (k == 1) ? 12 : 24;
        lat++;
        if (sv >= -(longint'(1) << (w - 1)) && sv < (longint'(1) << (w - 1))) begin
          found = 1'b1;
          op    = 2'(k);
          err   = 1'b0;
          imm   = 24'(sv & ((longint'(1) << w) - 1));
        end
      end
    end
  endfunction

  task automatic run_one(input logic [31:0] v, input logic [1:0] mn, input int hold,
                         input string tag);
    logic [1:0]  e_op;
    logic [23:0] e_imm;
    logic        e_err;
    int          e_lat;
    int          lat;
    int          wt;
    logic [31:0] rt;
    ref_model(v, mn, e_op, e_imm, e_err, e_lat);
    wt = 0;
    while (!bus.in_ready && wt < 10) begin
      @(posedge clk); @(negedge clk); wt++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++; $display("FAIL %s in_ready_timeout got=0 exp=1", tag); return;
    end
    bus.out_ready = (hold == 0);
    bus.value_in  = v;
    bus.min_op_in = mn;
    bus.in_valid  = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.value_in  = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 8) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL %s busy_in_ready got=%0b exp=0", tag, bus.in_ready);
      end
      @(posedge clk); @(negedge clk); lat++;
    end
    checks++;
    if (!bus.out_valid) begin
      errors++; $display("FAIL %s out_valid_timeout v=%h", tag, v); return;
    end
    checks++;
    if (lat !== e_lat) begin
      errors++; $display("FAIL %s latency v=%h got=%0d exp=%0d", tag, v, lat, e_lat);
    end
    checks++;
    if (bus.op_out !== e_op || bus.imm_out !== e_imm || bus.err_out !== e_err) begin
      errors++;
      $display("FAIL %s result v=%h min=%0d got op=%0d imm=%h err=%0b exp op=%0d imm=%h err=%0b",
               tag, v, mn, bus.op_out, bus.imm_out, bus.err_out, e_op, e_imm, e_err);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL %s done_in_ready got=%0b exp=0", tag, bus.in_ready);
    end
    if (!bus.err_out) begin
      case (bus.op_out)
        2'b00:   rt = {{24{bus.imm_out[7]}}, bus.imm_out[7:0]};
        2'b01:   rt = {{20{bus.imm_out[11]}}, bus.imm_out[11:0]};
        default: rt = {{8{bus.imm_out[23]}}, bus.imm_out};
      endcase
      checks++;
      if (rt !== v) begin
        errors++; $display("FAIL %s round_trip got=%h exp=%h", tag, rt, v);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.op_out !== e_op ||
          bus.imm_out !== e_imm || bus.err_out !== e_err) begin
        errors++;
        $display("FAIL %s hold cyc=%0d got vld=%0b rdy=%0b op=%0d imm=%h err=%0b exp vld=1 rdy=0 op=%0d imm=%h err=%0b",
                 tag, h, bus.out_valid, bus.in_ready, bus.op_out, bus.imm_out, bus.err_out,
                 e_op, e_imm, e_err);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release got rdy=%0b vld=%0b exp rdy=1 vld=0", tag, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imm_out !== 24'd0 || bus.op_out !== 2'b00 ||
        bus.err_out !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset got vld=%0b imm=%h op=%0d err=%0b rdy=%0b exp 0/0/0/0/1",
               bus.out_valid, bus.imm_out, bus.op_out, bus.err_out, bus.in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_op8();
    run_one(32'h0000007F, 2'b00, 0, "op8_127");
    run_one(32'hFFFFFF80, 2'b00, 0, "op8_m128");
    run_one(32'h00000000, 2'b00, 0, "op8_zero");
  endtask

  task automatic test_op12();
    run_one(32'hFFFFF800, 2'b00, 0, "op12_m2048");
    run_one(32'h00000080, 2'b00, 0, "op12_128");
    run_one(32'h000007FF, 2'b00, 0, "op12_2047");
  endtask

  task automatic test_op24_overflow();
    run_one(32'h00800000, 2'b00, 0, "ovf_8388608");
    run_one(32'hFF800000, 2'b00, 0, "op24_m8388608");
    run_one(32'h007FFFFF, 2'b00, 0, "op24_8388607");
    run_one(32'h80000000, 2'b00, 0, "ovf_min_int");
  endtask

  task automatic test_min_op();
    run_one(32'h00000005, 2'b10, 0, "min10_5");
    run_one(32'h00000005, 2'b11, 0, "min11_err");
    run_one(32'h0000007F, 2'b01, 0, "min01_127");
    run_one(32'hFFFFFFFF, 2'b10, 0, "min10_m1");
  endtask

  task automatic test_hold();
    run_one(32'h00000123, 2'b00, 5, "hold5");
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b1;
    bus.value_in  = 32'h00001000;
    bus.min_op_in = 2'b00;
    bus.in_valid  = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imm_out !== 24'd0 || bus.op_out !== 2'b00 ||
        bus.err_out !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid got vld=%0b imm=%h op=%0d err=%0b rdy=%0b exp 0/0/0/0/1",
               bus.out_valid, bus.imm_out, bus.op_out, bus.err_out, bus.in_ready);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_mid_discard cyc=%0d got vld=1 exp=0", i);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_one(32'h00000001, 2'b00, 0, "b2b_a");
    run_one(32'hFFFFF7FF, 2'b00, 0, "b2b_b");
    run_one(32'h00000800, 2'b00, 0, "b2b_c");
    run_one(32'h7FFFFFFF, 2'b01, 0, "b2b_d");
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [1:0]  mn;
    int          r;
    for (int i = 0; i < 10000; i++) begin
      v  = $urandom;
      v  = 32'($signed(v) >>> $urandom_range(31, 0));
      r  = $urandom_range(7, 0);
      mn = (r < 5) ? 2'b00 : 2'(r - 4);
      run_one(v, mn, (i % 97 == 0) ? 2 : 0, "rand");
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.value_in  = '0;
    bus.min_op_in = 2'b00;
    bus.out_ready = 1'b1;
    test_reset();
    test_op8();
    test_op12();
    test_op24_overflow();
    test_min_op();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
